lane_obstacle_gen: RTL and testbench
====================================

LANE_OBSTACLE_GEN -- requirements
Module: lane_obstacle_gen

Interface
REQ-001 Parameters SHALL be (name, default, meaning): NUM_LANES, 5, obstacle lanes stacked downward.
REQ-002 LANE_Y0, 260, top y of lane 0.
REQ-003 LANE_H, 32, lane height in pixels.
REQ-004 X_LEFT / X_RIGHT, 32 / 608, playfield x span [X_LEFT, X_RIGHT).
REQ-005 SPACING, 192, obstacle repeat period in pixels.
REQ-006 OBJ_W, 64, obstacle width in pixels; OBJ_W < SPACING.
REQ-007 SPD_W, 3, per-lane speed field width.
REQ-008 FROG_SIZE, 28, frog box edge in pixels.
REQ-009 Ports SHALL be (name, direction, width, meaning): clk, in, 1, pixel-domain clock.
REQ-010 reset, in, 1, asynchronous, active-low.
REQ-011 refresh_tick, in, 1, one-cycle frame strobe.
REQ-012 enable, in, 1, 0 freezes obstacle motion.
REQ-013 x, y, in, 10 each, current scan position.
REQ-014 video_on, in, 1, active display.
REQ-015 lane_speed, in, NUM_LANES*SPD_W, lane i speed at bits [i*SPD_W +: SPD_W].
REQ-016 lane_dir, in, NUM_LANES, 1 = rightward, 0 = leftward.
REQ-017 frog_l, frog_t, in, 10 each, frog box top-left corner.
REQ-018 obj_on, out, 1, registered obstacle-pixel flag.
REQ-019 obj_lane, out, $clog2(NUM_LANES), registered lane of obj_on.
REQ-020 hit, out, 1, one-cycle collision pulse.
REQ-021 hit_lane, out, $clog2(NUM_LANES), lane of the first overlap, held until the next hit.

Function
REQ-022 Per-lane offset off[i] SHALL lie in [0, SPACING); on refresh_tick with enable=1: dir=1 -> off = (off + spd) mod SPACING; dir=0 -> off = (off - spd) mod SPACING, with wrap-around in both directions.
REQ-023 Speed 0 SHALL hold the offset; enable=0 SHALL hold all offsets.
REQ-024 Lane i SHALL be active when y is in [LANE_Y0 + i*LANE_H, LANE_Y0 + (i+1)*LANE_H); at most one lane is active.
REQ-025 Obstacle pixel SHALL be true iff the lane is active, x is in [X_LEFT, X_RIGHT), and ((x - X_LEFT + SPACING - off[i]) mod SPACING) < OBJ_W.
REQ-026 The modulo SHALL be realised by one column-phase counter: loaded at x == X_LEFT with (SPACING - off[i]) mod SPACING, incremented per clk, wrapping SPACING-1 -> 0; no dividers.
REQ-027 obj_on and obj_lane SHALL have exactly 1 clk of latency from x/y, matching frog ROM latency.
REQ-028 obj_on SHALL be forced to 0 when video_on=0.
REQ-029 The overlap latch SHALL set when the registered obstacle pixel is true and the delayed (x, y) is inside the frog box [frog_l, frog_l + FROG_SIZE - 1] x [frog_t, frog_t + FROG_SIZE - 1].
REQ-030 On the first overlap of a frame, hit_lane SHALL capture the lane; later overlaps in the same frame SHALL NOT change it.
REQ-031 On refresh_tick, hit SHALL pulse 1 for one clk if the latch is set, and the latch SHALL clear in the same cycle.
REQ-032 If an overlap and refresh_tick coincide, the overlap SHALL count toward the next frame.
REQ-033 Offsets SHALL update on refresh_tick only, so a frame is never rendered with mixed offsets.

Reset
REQ-034 While reset=0: off[i]=0, phase counter=0, latch=0, obj_on=0, obj_lane=0, hit=0, hit_lane=0.
REQ-035 Reset asserted mid-frame SHALL discard any pending overlap; the first refresh_tick after release SHALL produce no hit.

Structure
REQ-036 Playfield geometry constants (X_LEFT, X_RIGHT, lane base, FROG_SIZE) SHALL live in the shared game package; this block's defaults SHALL reference them.
REQ-037 One sub-module, lane_offset, SHALL hold a single lane's offset register and signed wrap arithmetic; it is instantiated NUM_LANES times via generate.

Verification
REQ-038 Reset, then 1 refresh_tick with lane0 speed=3 dir=1 -> off[0]=3; scan y=260 -> obj_on=1 for x in [35, 99) and [227, 291), 1 clk late.
REQ-039 off[0]=190, speed=4, dir=1, refresh_tick -> off[0]=2; speed=4, dir=0 from off=2 -> 190.
REQ-040 Frog at (40, 265), off[0]=0, one full frame scanned -> exactly one hit pulse at the next refresh_tick, hit_lane=0.
REQ-041 Frog at (100, 300), lane 1, off=0 -> no hit; set enable=0 for 10 frames -> off values unchanged.
REQ-042 Overlap pixel coincident with refresh_tick -> no hit this tick; hit at the following tick.
REQ-043 Assert reset mid-frame after an overlap -> no hit at the next refresh_tick; all outputs 0 during reset.

Source files
------------

// File: rtl/lane_obstacle_gen_pkg.sv
// Shared playfield geometry and scan-pixel payload for the lane obstacle generator.
package lane_obstacle_gen_pkg;

    localparam int unsigned COORD_W      = 10;
    localparam int unsigned PF_X_LEFT    = 32;
    localparam int unsigned PF_X_RIGHT   = 608;
    localparam int unsigned PF_LANE_Y0   = 260;
    localparam int unsigned PF_FROG_SIZE = 28;

    // Registered obstacle pixel together with the scan position it belongs to.
    typedef struct packed {
        logic               on;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } scan_pix_t;

    // Inclusive range test on coordinates widened by one bit to absorb lo + size overflow.
    function automatic logic in_span(input logic [COORD_W:0] v,
                                     input logic [COORD_W:0] lo,
                                     input logic [COORD_W:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/lane_obstacle_gen_lane_offset.sv
// One lane's scroll offset: moves by +/-spd per enabled frame tick, wrapping within [0, SPACING).
module lane_offset
    import lane_obstacle_gen_pkg::*;
#(
    parameter int unsigned SPACING = 192,
    parameter int unsigned SPD_W   = 3,
    parameter int unsigned OFF_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             refresh_tick,
    input  logic             enable,
    input  logic [SPD_W-1:0] spd,
    input  logic             dir,
    output logic [OFF_W-1:0] off
);

    localparam int unsigned          SW   = OFF_W + 2;
    localparam logic signed [SW-1:0] SPAN = SW'(SPACING);

    logic [OFF_W-1:0]     off_q, off_d;
    logic signed [SW-1:0] step_c, sum_c;

    // Signed step then a single-sided correction back into [0, SPACING).
    always_comb begin
        off_d  = off_q;
        step_c = $signed(SW'(spd));
        if (!dir) begin
            step_c = -step_c;
        end
        sum_c = $signed(SW'(off_q)) + step_c;
        if (sum_c[SW-1]) begin
            sum_c = sum_c + SPAN;
        end else if (sum_c >= SPAN) begin
            sum_c = sum_c - SPAN;
        end
        if (refresh_tick && enable) begin
            off_d = OFF_W'(sum_c);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            off_q <= '0;
        end else begin
            off_q <= off_d;
        end
    end

    assign off = off_q;

endmodule

// File: rtl/lane_obstacle_gen.sv
// Scrolling lane obstacle renderer with frame-level frog collision detection.
module lane_obstacle_gen
    import lane_obstacle_gen_pkg::*;
#(
    parameter int unsigned NUM_LANES = 5,
    parameter int unsigned LANE_Y0   = PF_LANE_Y0,
    parameter int unsigned LANE_H    = 32,
    parameter int unsigned X_LEFT    = PF_X_LEFT,
    parameter int unsigned X_RIGHT   = PF_X_RIGHT,
    parameter int unsigned SPACING   = 192,
    parameter int unsigned OBJ_W     = 64,
    parameter int unsigned SPD_W     = 3,
    parameter int unsigned FROG_SIZE = PF_FROG_SIZE
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         refresh_tick,
    input  logic                         enable,
    input  logic [COORD_W-1:0]           x,
    input  logic [COORD_W-1:0]           y,
    input  logic                         video_on,
    input  logic [NUM_LANES*SPD_W-1:0]   lane_speed,
    input  logic [NUM_LANES-1:0]         lane_dir,
    input  logic [COORD_W-1:0]           frog_l,
    input  logic [COORD_W-1:0]           frog_t,
    output logic                         obj_on,
    output logic [$clog2(NUM_LANES)-1:0] obj_lane,
    output logic                         hit,
    output logic [$clog2(NUM_LANES)-1:0] hit_lane
);

    localparam int unsigned        LANE_W = $clog2(NUM_LANES);
    localparam int unsigned        OFF_W  = $clog2(SPACING);
    localparam logic [COORD_W-1:0] XL     = COORD_W'(X_LEFT);
    localparam logic [COORD_W-1:0] XR     = COORD_W'(X_RIGHT);
    localparam logic [OFF_W-1:0]   PH_MAX = OFF_W'(SPACING - 1);
    localparam logic [OFF_W-1:0]   OBJ_WV = OFF_W'(OBJ_W);
    localparam logic [COORD_W:0]   FROG_E = (COORD_W+1)'(FROG_SIZE - 1);

    logic [OFF_W-1:0] off_w [NUM_LANES];

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        lane_offset #(
            .SPACING (SPACING),
            .SPD_W   (SPD_W),
            .OFF_W   (OFF_W)
        ) u_off (
            .clk          (clk),
            .reset        (reset),
            .refresh_tick (refresh_tick),
            .enable       (enable),
            .spd          (lane_speed[gi*SPD_W +: SPD_W]),
            .dir          (lane_dir[gi]),
            .off          (off_w[gi])
        );
    end

    logic              lane_act_c;
    logic [LANE_W-1:0] lane_idx_c;
    logic [OFF_W-1:0]  lane_off_c;

    // Lanes are disjoint bands of rows, so at most one matches.
    always_comb begin
        lane_act_c = 1'b0;
        lane_idx_c = '0;
        lane_off_c = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            if ((32'(y) >= LANE_Y0 + i*LANE_H) && (32'(y) < LANE_Y0 + (i+1)*LANE_H)) begin
                lane_act_c = 1'b1;
                lane_idx_c = LANE_W'(i);
                lane_off_c = off_w[i];
            end
        end
    end

    logic [OFF_W-1:0]  phase_q, phase_d, phase_c, load_c;
    scan_pix_t         pix_q, pix_d;
    logic [LANE_W-1:0] obj_lane_q, obj_lane_d;

    // Column phase replaces the modulo: seeded at the left edge, then counts one per pixel.
    always_comb begin
        load_c     = (lane_off_c == '0) ? '0 : OFF_W'(SPACING) - lane_off_c;
        phase_c    = (x == XL) ? load_c : phase_q;
        phase_d    = (phase_c == PH_MAX) ? '0 : phase_c + OFF_W'(1);
        pix_d.on   = video_on && lane_act_c && (x >= XL) && (x < XR) && (phase_c < OBJ_WV);
        pix_d.x    = x;
        pix_d.y    = y;
        obj_lane_d = lane_idx_c;
    end

    logic              latch_q, latch_d;
    logic              hit_q, hit_d;
    logic [LANE_W-1:0] hit_lane_q, hit_lane_d;
    logic              overlap_c;

    // An overlap seen on the tick cycle belongs to the frame that starts with that tick.
    always_comb begin
        overlap_c  = pix_q.on
                  && in_span({1'b0, pix_q.x}, {1'b0, frog_l}, {1'b0, frog_l} + FROG_E)
                  && in_span({1'b0, pix_q.y}, {1'b0, frog_t}, {1'b0, frog_t} + FROG_E);
        latch_d    = latch_q;
        hit_d      = 1'b0;
        hit_lane_d = hit_lane_q;
        if (refresh_tick) begin
            hit_d   = latch_q;
            latch_d = overlap_c;
        end else if (overlap_c) begin
            latch_d = 1'b1;
        end
        if (overlap_c && (refresh_tick || !latch_q)) begin
            hit_lane_d = obj_lane_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q    <= '0;
            pix_q      <= '0;
            obj_lane_q <= '0;
            latch_q    <= 1'b0;
            hit_q      <= 1'b0;
            hit_lane_q <= '0;
        end else begin
            phase_q    <= phase_d;
            pix_q      <= pix_d;
            obj_lane_q <= obj_lane_d;
            latch_q    <= latch_d;
            hit_q      <= hit_d;
            hit_lane_q <= hit_lane_d;
        end
    end

    assign obj_on   = pix_q.on;
    assign obj_lane = obj_lane_q;
    assign hit      = hit_q;
    assign hit_lane = hit_lane_q;

endmodule

// File: tb/tb_lane_obstacle_gen.sv
// Directed bench for lane_obstacle_gen: pixel pattern, offset wrap, enable hold and collision pulses.
module tb_lane_obstacle_gen;

    logic        clk;
    logic        reset;
    logic        refresh_tick;
    logic        enable;
    logic [9:0]  x, y;
    logic        video_on;
    logic [14:0] lane_speed;
    logic [4:0]  lane_dir;
    logic [9:0]  frog_l, frog_t;
    logic        obj_on;
    logic [2:0]  obj_lane;
    logic        hit;
    logic [2:0]  hit_lane;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_off [5];

    lane_obstacle_gen dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .enable       (enable),
        .x            (x),
        .y            (y),
        .video_on     (video_on),
        .lane_speed   (lane_speed),
        .lane_dir     (lane_dir),
        .frog_l       (frog_l),
        .frog_t       (frog_t),
        .obj_on       (obj_on),
        .obj_lane     (obj_lane),
        .hit          (hit),
        .hit_lane     (hit_lane)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int lane_of(input int yy);
        if (yy >= 260 && yy < 420) return (yy - 260) / 32;
        return -1;
    endfunction

    function automatic bit exp_pix(input int xx, input int yy);
        int l;
        l = lane_of(yy);
        if (l < 0 || xx < 32 || xx >= 608) return 1'b0;
        return ((xx - 32 + 192 - exp_off[l]) % 192) < 64;
    endfunction

    task automatic set_lane(input int l, input int spd, input bit d);
        lane_speed[l*3 +: 3] = 3'(spd);
        lane_dir[l]          = d;
    endtask

    task automatic check_pix(input int px, input int py, input bit vid);
        bit e;
        e = exp_pix(px, py) && vid;
        check($sformatf("pix_x%0d_y%0d", px, py), 32'(obj_on), 32'(e));
        if (e) check($sformatf("lane_x%0d_y%0d", px, py), 32'(obj_lane), 32'(lane_of(py)));
    endtask

    // Drive one raster row x0..x1, checking each pixel one clock after it is presented.
    task automatic scan_line(input int yy, input int x0, input int x1, input bit vid);
        int px;
        for (int xx = x0; xx <= x1; xx++) begin
            @(negedge clk);
            if (xx > x0) check_pix(px, yy, vid);
            x = 10'(xx); y = 10'(yy); video_on = vid;
            px = xx;
        end
        @(negedge clk);
        check_pix(px, yy, vid);
        x = 10'd0; y = 10'd0; video_on = 1'b1;
    endtask

    task automatic do_tick(input int exp_hit, input int exp_lane, input bit chk_lane);
        @(negedge clk);
        refresh_tick = 1'b1; x = 10'd0; y = 10'd0;
        @(negedge clk);
        refresh_tick = 1'b0;
        if (enable) begin
            for (int i = 0; i < 5; i++) begin
                if (lane_dir[i]) exp_off[i] = (exp_off[i] + int'(lane_speed[i*3 +: 3])) % 192;
                else             exp_off[i] = (exp_off[i] + 192 - int'(lane_speed[i*3 +: 3])) % 192;
            end
        end
        check("hit", 32'(hit), 32'(exp_hit));
        if (chk_lane) check("hit_lane", 32'(hit_lane), 32'(exp_lane));
        @(negedge clk);
        check("hit_pulse_end", 32'(hit), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; refresh_tick = 1'b0; video_on = 1'b1; x = 10'd40; y = 10'd260;
        repeat (2) @(negedge clk);
        check("rst_obj_on",   32'(obj_on),   32'd0);
        check("rst_obj_lane", 32'(obj_lane), 32'd0);
        check("rst_hit",      32'(hit),      32'd0);
        check("rst_hit_lane", 32'(hit_lane), 32'd0);
        reset = 1'b1; x = 10'd0; y = 10'd0;
        for (int i = 0; i < 5; i++) exp_off[i] = 0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; refresh_tick = 1'b0; enable = 1'b1; video_on = 1'b1;
        x = 10'd0; y = 10'd0; lane_speed = '0; lane_dir = '0;
        frog_l = 10'd0; frog_t = 10'd0;
        for (int i = 0; i < 5; i++) exp_off[i] = 0;

        do_reset();

        // lane 0 right by 3, lane 1 left by 1 (wraps to 191)
        set_lane(0, 3, 1'b1); set_lane(1, 1, 1'b0);
        do_tick(0, 0, 0);
        set_lane(1, 0, 1'b0);
        scan_line(260, 28, 620, 1'b1);
        scan_line(300, 28, 300, 1'b1);
        scan_line(260, 28, 120, 1'b0);

        // 3 -> 0 -> 190 leftward, then 190 -> 2 rightward, then 2 -> 190 leftward
        set_lane(0, 3, 1'b0); do_tick(0, 0, 0);
        set_lane(0, 2, 1'b0); do_tick(0, 0, 0);
        scan_line(261, 28, 620, 1'b1);
        set_lane(0, 4, 1'b1); do_tick(0, 0, 0);
        scan_line(262, 28, 620, 1'b1);
        set_lane(0, 4, 1'b0); do_tick(0, 0, 0);
        scan_line(263, 28, 620, 1'b1);
        set_lane(0, 0, 1'b1);

        // frog over lane 0 for a whole frame: one hit, lane 0
        do_reset();
        frog_l = 10'd40; frog_t = 10'd265;
        for (int yy = 258; yy < 300; yy++) scan_line(yy, 28, 120, 1'b1);
        do_tick(1, 0, 1);
        do_tick(0, 0, 0);

        // frog clear of lane 1 obstacles; frozen offsets while disabled
        frog_l = 10'd100; frog_t = 10'd300;
        for (int yy = 292; yy < 331; yy++) scan_line(yy, 28, 140, 1'b1);
        do_tick(0, 0, 0);
        set_lane(0, 5, 1'b1); set_lane(2, 7, 1'b0);
        enable = 1'b0;
        repeat (10) do_tick(0, 0, 0);
        scan_line(260, 28, 300, 1'b1);
        scan_line(330, 28, 300, 1'b1);
        set_lane(0, 0, 1'b1); set_lane(2, 0, 1'b0);
        enable = 1'b1;

        // right edge of obstacle [32,96): frog at 96 misses, at 95 hits
        frog_l = 10'd96; frog_t = 10'd265;
        scan_line(265, 28, 140, 1'b1);
        do_tick(0, 0, 0);
        frog_l = 10'd95;
        scan_line(265, 28, 140, 1'b1);
        do_tick(1, 0, 1);

        // overlap on the tick cycle counts toward the following frame
        frog_l = 10'd40; frog_t = 10'd265;
        for (int xx = 28; xx <= 40; xx++) begin
            @(negedge clk);
            x = 10'(xx); y = 10'd265;
        end
        @(negedge clk);
        refresh_tick = 1'b1; x = 10'd41; y = 10'd0;
        @(negedge clk);
        refresh_tick = 1'b0; x = 10'd0;
        check("coinc_hit", 32'(hit), 32'd0);
        do_tick(1, 0, 1);

        // first overlap of the frame (lane 2) wins over a later one (lane 3)
        frog_l = 10'd40; frog_t = 10'd340;
        scan_line(345, 28, 120, 1'b1);
        scan_line(360, 28, 120, 1'b1);
        do_tick(1, 2, 1);

        // reset after an overlap discards it
        frog_l = 10'd40; frog_t = 10'd330;
        scan_line(335, 28, 120, 1'b1);
        do_reset();
        do_tick(0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
